// File: rtl/sprite_blitter.sv
// Copies one palette-indexed sprite from a synchronous ROM into the framebuffer,
// with signed placement, optional horizontal mirror, transparency and screen clipping.
module sprite_blitter #(
    parameter int unsigned SPR_W      = 100,
    parameter int unsigned SPR_H      = 100,
    parameter int unsigned FB_W       = 640,
    parameter int unsigned FB_H       = 480,
    parameter int unsigned IDX_W      = 12,
    parameter int unsigned TRANSP_IDX = 0,
    parameter int unsigned ROM_AW     = 14,
    parameter int unsigned FB_AW      = 19
) (
    input  logic                vga_clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic signed [10:0]  spr_x,
    input  logic signed [10:0]  spr_y,
    input  logic                flip_h,
    output logic                busy,
    output logic                done,
    output logic [ROM_AW-1:0]   rom_addr,
    input  logic [IDX_W-1:0]    rom_q,
    input  logic                fb_grant,
    output logic                fb_we,
    output logic [FB_AW-1:0]    fb_addr,
    output logic [IDX_W-1:0]    fb_data
);

    localparam int unsigned POS_W = 11;
    localparam int unsigned CW    = POS_W + 1;
    localparam int unsigned COL_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int unsigned ROW_W = (SPR_H > 1) ? $clog2(SPR_H + 1) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                  state_q;
    state_t                  state_d;

    logic [COL_W-1:0]        col_q;
    logic [ROW_W-1:0]        row_q;
    logic signed [POS_W-1:0] x0_q;
    logic signed [POS_W-1:0] y0_q;
    logic                    flip_q;
    logic                    busy_q;
    logic                    done_q;
    logic [ROM_AW-1:0]       rom_addr_q;
    logic                    s1_valid_q;
    logic                    s1_in_fb_q;
    logic [FB_AW-1:0]        s1_fb_addr_q;
    logic [FB_AW-1:0]        wr_addr_q;
    logic [IDX_W-1:0]        wr_data_q;

    logic                    accept;
    logic                    issue;
    logic                    last_pix;
    logic [COL_W-1:0]        col_eff;
    logic [ROM_AW-1:0]       rom_addr_calc;
    logic signed [CW-1:0]    px;
    logic signed [CW-1:0]    py;
    logic                    x_ok;
    logic                    y_ok;
    logic [FB_AW-1:0]        fb_addr_calc;

    // State register
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; a pixel is issued only on granted FETCH cycles
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        issue    = 1'b0;
        last_pix = (row_q == ROW_W'(SPR_H - 1)) && (col_q == COL_W'(SPR_W - 1));
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (fb_grant) begin
                    issue = 1'b1;
                    if (last_pix) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (fb_grant) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Address generation and clip test for the pixel at the counters
    always_comb begin
        col_eff       = flip_q ? (COL_W'(SPR_W - 1) - col_q) : col_q;
        rom_addr_calc = ROM_AW'(32'(row_q) * 32'(SPR_W) + 32'(col_eff));
        px            = CW'(x0_q) + $signed(CW'(col_q));
        py            = CW'(y0_q) + $signed(CW'(row_q));
        x_ok          = !px[CW-1] && (px < $signed(CW'(FB_W)));
        y_ok          = !py[CW-1] && (py < $signed(CW'(FB_H)));
        fb_addr_calc  = FB_AW'(32'($unsigned(py)) * 32'(FB_W) + 32'($unsigned(px)));
    end

    // Counters, issue stage and write-port hold registers
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            col_q        <= '0;
            row_q        <= '0;
            x0_q         <= '0;
            y0_q         <= '0;
            flip_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rom_addr_q   <= '0;
            s1_valid_q   <= 1'b0;
            s1_in_fb_q   <= 1'b0;
            s1_fb_addr_q <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            busy_q <= (state_d != IDLE);
            done_q <= (state_q == DRAIN) && (state_d == IDLE);
            if (accept) begin
                x0_q   <= spr_x;
                y0_q   <= spr_y;
                flip_q <= flip_h;
                col_q  <= '0;
                row_q  <= '0;
            end else if (issue) begin
                if (col_q == COL_W'(SPR_W - 1)) begin
                    col_q <= '0;
                    row_q <= row_q + ROW_W'(1);
                end else begin
                    col_q <= col_q + COL_W'(1);
                end
                rom_addr_q <= rom_addr_calc;
            end
            if (fb_grant) begin
                s1_valid_q   <= issue;
                s1_in_fb_q   <= x_ok && y_ok;
                s1_fb_addr_q <= fb_addr_calc;
            end
            if (fb_we) begin
                wr_addr_q <= s1_fb_addr_q;
                wr_data_q <= rom_q;
            end
        end
    end

    // During a stall the last issued address is re-presented so rom_q stays aligned with stage 1
    assign rom_addr = issue ? rom_addr_calc : rom_addr_q;
    // The write lands in the same cycle as rom_q, gated by the grant of that cycle
    assign fb_we    = s1_valid_q && s1_in_fb_q && fb_grant && (rom_q != IDX_W'(TRANSP_IDX));
    assign fb_addr  = fb_we ? s1_fb_addr_q : wr_addr_q;
    assign fb_data  = fb_we ? rom_q : wr_data_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: a write scoreboard filled from a reference
// model of the blit, drained by a framebuffer-port monitor.
module tb_sprite_blitter;

    localparam int SPR_W  = 100;
    localparam int SPR_H  = 100;
    localparam int FB_W   = 640;
    localparam int FB_H   = 480;
    localparam int IDX_W  = 12;
    localparam int ROM_AW = 14;
    localparam int FB_AW  = 19;
    localparam int NPIX   = SPR_W * SPR_H;

    logic                   vga_clk = 1'b0;
    logic                   reset_n;
    logic                   start;
    logic signed [10:0]     spr_x;
    logic signed [10:0]     spr_y;
    logic                   flip_h;
    logic                   busy;
    logic                   done;
    logic [ROM_AW-1:0]      rom_addr;
    logic [IDX_W-1:0]       rom_q = '0;
    logic                   fb_grant;
    logic                   fb_we;
    logic [FB_AW-1:0]       fb_addr;
    logic [IDX_W-1:0]       fb_data;

    typedef struct packed {
        logic [FB_AW-1:0] addr;
        logic [IDX_W-1:0] data;
    } wr_t;

    wr_t              sb[$];
    wr_t              mon_e;
    logic [IDX_W-1:0] rom_mem [NPIX];
    int               n_pass = 0;
    int               n_fail = 0;
    int               wr_cnt = 0;
    int               stall_at[$];
    int               poke_at = -1;

    sprite_blitter #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .FB_W(FB_W), .FB_H(FB_H),
        .IDX_W(IDX_W), .TRANSP_IDX(0), .ROM_AW(ROM_AW), .FB_AW(FB_AW)
    ) dut (
        .vga_clk  (vga_clk),
        .reset_n  (reset_n),
        .start    (start),
        .spr_x    (spr_x),
        .spr_y    (spr_y),
        .flip_h   (flip_h),
        .busy     (busy),
        .done     (done),
        .rom_addr (rom_addr),
        .rom_q    (rom_q),
        .fb_grant (fb_grant),
        .fb_we    (fb_we),
        .fb_addr  (fb_addr),
        .fb_data  (fb_data)
    );

    always #5 vga_clk = ~vga_clk;

    // Synchronous sprite ROM
    always @(posedge vga_clk) begin
        if (rom_addr < ROM_AW'(NPIX)) rom_q <= rom_mem[rom_addr];
        else                          rom_q <= '0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Framebuffer port monitor
    always @(negedge vga_clk) begin
        if (reset_n === 1'b1 && fb_we === 1'b1) begin
            wr_cnt++;
            chk("write_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("fb_addr", 32'(fb_addr), 32'(mon_e.addr));
                chk("fb_data", 32'(fb_data), 32'(mon_e.data));
            end
        end
    end

    task automatic fill_rom_mod7();
        for (int a = 0; a < NPIX; a++) rom_mem[a] = IDX_W'(a % 7 + 1);
    endtask

    task automatic fill_rom_single();
        for (int a = 0; a < NPIX; a++) rom_mem[a] = '0;
        rom_mem[0] = IDX_W'(5);
    endtask

    task automatic push_model(input int sx, input int sy, input bit fl);
        wr_t e;
        int  x, y, d;
        for (int r = 0; r < SPR_H; r++) begin
            for (int c = 0; c < SPR_W; c++) begin
                x = sx + c;
                y = sy + r;
                d = int'(rom_mem[r * SPR_W + (fl ? SPR_W - 1 - c : c)]);
                if (x >= 0 && x < FB_W && y >= 0 && y < FB_H && d != 0) begin
                    e.addr = FB_AW'(y * FB_W + x);
                    e.data = IDX_W'(d);
                    sb.push_back(e);
                end
            end
        end
    endtask

    task automatic blit(input string tag, input int sx, input int sy, input bit fl,
                        input int exp_busy, input int exp_wr);
        int nbusy;
        bit seen;
        int wr0;
        nbusy = 0;
        seen  = 1'b0;
        @(posedge vga_clk); #1;
        spr_x = 11'(sx); spr_y = 11'(sy); flip_h = fl; start = 1'b1; fb_grant = 1'b1;
        wr0 = wr_cnt;
        @(posedge vga_clk); #1;
        // Scramble the inputs: only the values at acceptance may matter
        start = 1'b0; spr_x = 11'sd700; spr_y = -11'sd300; flip_h = !fl;
        for (int cyc = 1; cyc <= exp_busy + 20 && !seen; cyc++) begin
            fb_grant = 1'b1;
            foreach (stall_at[i]) if (stall_at[i] == cyc) fb_grant = 1'b0;
            start = (cyc == poke_at);
            if (busy) nbusy++;
            else begin
                seen = 1'b1;
                chk({tag, "_done_pulse"}, 32'(done), 32'd1);
                chk({tag, "_busy_cycles"}, 32'(nbusy), 32'(exp_busy));
            end
            if (!seen) begin
                @(posedge vga_clk); #1;
            end
        end
        start = 1'b0; fb_grant = 1'b1;
        chk({tag, "_finished"}, 32'(seen), 32'd1);
        chk({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
        chk({tag, "_write_count"}, 32'(wr_cnt - wr0), 32'(exp_wr));
        @(posedge vga_clk); #1;
        chk({tag, "_done_low"}, 32'(done), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        sb.delete();
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_fb_we"}, 32'(fb_we), 32'd0);
        chk({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
        chk({tag, "_fb_addr"}, 32'(fb_addr), 32'd0);
        chk({tag, "_fb_data"}, 32'(fb_data), 32'd0);
    endtask

    initial begin
        wr_t e;
        reset_n = 1'b0; start = 1'b0; spr_x = '0; spr_y = '0; flip_h = 1'b0; fb_grant = 1'b1;
        fill_rom_mod7();
        #12;
        check_zero_outputs("reset");
        @(posedge vga_clk); #1;
        reset_n = 1'b1;

        // Plain copy at the origin
        push_model(0, 0, 1'b0);
        blit("t1", 0, 0, 1'b0, 10001, 10000);

        // Mirrored copy
        push_model(0, 0, 1'b1);
        blit("t2", 0, 0, 1'b1, 10001, 10000);

        // Clipped on the left and bottom edges
        push_model(-50, 430, 1'b0);
        blit("t3", -50, 430, 1'b0, 10001, 2500);

        // Single opaque pixel at (10,20)
        fill_rom_single();
        e.addr = FB_AW'(12810);
        e.data = IDX_W'(5);
        sb.push_back(e);
        blit("t4", 10, 20, 1'b0, 10001, 1);

        // Three stall cycles plus an ignored start while busy
        fill_rom_mod7();
        stall_at.push_back(int'($urandom_range(2, 3000)));
        stall_at.push_back(int'($urandom_range(3001, 6000)));
        stall_at.push_back(int'($urandom_range(6001, 9000)));
        poke_at = 300;
        push_model(0, 0, 1'b0);
        blit("t5", 0, 0, 1'b0, 10004, 10000);
        stall_at.delete();
        poke_at = -1;

        // Asynchronous reset in the middle of a blit
        push_model(0, 0, 1'b0);
        @(posedge vga_clk); #1;
        spr_x = '0; spr_y = '0; flip_h = 1'b0; start = 1'b1;
        @(posedge vga_clk); #1;
        start = 1'b0;
        repeat (500) @(posedge vga_clk);
        #3;
        reset_n = 1'b0;
        #1;
        check_zero_outputs("t6_async_reset");
        sb.delete();
        repeat (2) @(posedge vga_clk);
        #1;
        reset_n = 1'b1;
        repeat (30) @(posedge vga_clk);
        #1;
        chk("t6_idle_after_reset", 32'(busy), 32'd0);
        push_model(0, 0, 1'b0);
        blit("t6_restart", 0, 0, 1'b0, 10001, 10000);

        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
